// File: rtl/n64_pif_pkg.sv
// Shared types and widths for the PIF RAM port-A arbiter.
package n64_pif_pkg;

    localparam int unsigned PIF_RAM_AW = 11;
    localparam int unsigned PIF_RAM_DW = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1
    } arb_state_e;

    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/n64_pif_arb_fsm.sv
// Round-robin ownership FSM with bounded bursts; reports which requester is issued this cycle.
module n64_pif_arb_fsm
    import n64_pif_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    r0_req,
    input  logic    r1_req,
    input  logic    lock,
    output logic    issue,
    output req_id_e owner
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    req_id_e       last_q, last_d;

    logic own_req;
    logic oth_req;
    logic hold;

    assign own_req = (state_q == ARB_OWN1) ? r1_req : r0_req;
    assign oth_req = (state_q == ARB_OWN1) ? r0_req : r1_req;
    assign hold    = (state_q == ARB_OWN0) && lock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            count_q <= '0;
            last_q  <= REQ_R1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        issue   = 1'b0;
        owner   = REQ_R0;
        case (state_q)
            ARB_IDLE: begin
                count_d = '0;
                if (r0_req && (last_q == REQ_R1 || !r1_req)) begin
                    state_d = ARB_OWN0;
                end else if (r1_req) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                owner = (state_q == ARB_OWN1) ? REQ_R1 : REQ_R0;
                issue = own_req;
                // Count saturates so a late request from the other side still forces a yield.
                if (own_req && count_q != MAX_CNT) begin
                    count_d = count_q + CW'(1);
                end
                if (!own_req) begin
                    count_d = '0;
                    if (oth_req) begin
                        state_d = (state_q == ARB_OWN0) ? ARB_OWN1 : ARB_OWN0;
                    end else begin
                        state_d = ARB_IDLE;
                        last_d  = owner;
                    end
                end else if (count_d == MAX_CNT && oth_req && !hold) begin
                    state_d = (state_q == ARB_OWN0) ? ARB_OWN1 : ARB_OWN0;
                    count_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: rtl/n64_pif_ram_arbiter.sv
// Two-requester arbiter for PIF RAM port A with 1-deep read tag steering.
// Optional PIF_RAM_ARB_LOCK_EN adds r0_lock, suppressing R0's burst yield while held.
module n64_pif_ram_arbiter
    import n64_pif_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [PIF_RAM_AW-1:0] r0_addr,
    input  logic [PIF_RAM_DW-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [PIF_RAM_DW-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [PIF_RAM_AW-1:0] r1_addr,
    input  logic [PIF_RAM_DW-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [PIF_RAM_DW-1:0] r1_rdata,
`ifdef PIF_RAM_ARB_LOCK_EN
    input  logic                  r0_lock,
`endif
    output logic [PIF_RAM_AW-1:0] ram_addr,
    output logic                  ram_wren,
    output logic [PIF_RAM_DW-1:0] ram_wdata,
    output logic                  ram_oe,
    input  logic [PIF_RAM_DW-1:0] ram_q,
    input  logic                  ram_valid
);

    logic    issue;
    req_id_e owner;
    logic    lock;

`ifdef PIF_RAM_ARB_LOCK_EN
    assign lock = r0_lock;
`else
    assign lock = 1'b0;
`endif

    n64_pif_arb_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_fsm (
        .clk   (clk),
        .reset (reset),
        .r0_req(r0_req),
        .r1_req(r1_req),
        .lock  (lock),
        .issue (issue),
        .owner (owner)
    );

    logic                  sel_we;
    logic [PIF_RAM_AW-1:0] sel_addr;
    logic [PIF_RAM_DW-1:0] sel_wdata;
    logic [PIF_RAM_AW-1:0] addr_q;
    logic [PIF_RAM_DW-1:0] wdata_q;
    logic                  tag_v_q;
    req_id_e               tag_id_q;
    logic [PIF_RAM_DW-1:0] r0_rdata_q;
    logic [PIF_RAM_DW-1:0] r1_rdata_q;

    assign sel_we    = (owner == REQ_R1) ? r1_we    : r0_we;
    assign sel_addr  = (owner == REQ_R1) ? r1_addr  : r0_addr;
    assign sel_wdata = (owner == REQ_R1) ? r1_wdata : r0_wdata;

    assign r0_gnt    = issue && (owner == REQ_R0);
    assign r1_gnt    = issue && (owner == REQ_R1);
    assign ram_wren  = issue && sel_we;
    assign ram_oe    = issue && !sel_we;
    // Address and write data hold their last issued value on idle cycles.
    assign ram_addr  = issue ? sel_addr  : addr_q;
    assign ram_wdata = issue ? sel_wdata : wdata_q;

    assign r0_rvalid = ram_valid && tag_v_q && (tag_id_q == REQ_R0);
    assign r1_rvalid = ram_valid && tag_v_q && (tag_id_q == REQ_R1);
    assign r0_rdata  = r0_rvalid ? ram_q : r0_rdata_q;
    assign r1_rdata  = r1_rvalid ? ram_q : r1_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            tag_v_q    <= 1'b0;
            tag_id_q   <= REQ_R0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else begin
            addr_q   <= ram_addr;
            wdata_q  <= ram_wdata;
            tag_v_q  <= ram_oe;
            tag_id_q <= owner;
            if (r0_rvalid) r0_rdata_q <= ram_q;
            if (r1_rvalid) r1_rdata_q <= ram_q;
        end
    end

endmodule

// File: tb/tb_n64_pif_ram_arbiter.sv
// Randomized bench for n64_pif_ram_arbiter against a cycle-level reference model and RAM model.
module tb_n64_pif_ram_arbiter;
    import n64_pif_pkg::*;

    localparam int MAX_BURST = 8;
`ifdef PIF_RAM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct {
        bit         we;
        logic [10:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [10:0] r0_addr = '0, r1_addr = '0;
    logic [7:0]  r0_wdata = '0, r1_wdata = '0;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0]  r0_rdata, r1_rdata;
`ifdef PIF_RAM_ARB_LOCK_EN
    logic        r0_lock = 1'b0;
`endif
    logic [10:0] ram_addr;
    logic        ram_wren, ram_oe;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_q = 8'h00;
    logic        ram_valid = 1'b0;

    always #5 clk = ~clk;

    n64_pif_ram_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .reset    (reset),
        .r0_req   (r0_req),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_gnt   (r0_gnt),
        .r0_rvalid(r0_rvalid),
        .r0_rdata (r0_rdata),
        .r1_req   (r1_req),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_gnt   (r1_gnt),
        .r1_rvalid(r1_rvalid),
        .r1_rdata (r1_rdata),
`ifdef PIF_RAM_ARB_LOCK_EN
        .r0_lock  (r0_lock),
`endif
        .ram_addr (ram_addr),
        .ram_wren (ram_wren),
        .ram_wdata(ram_wdata),
        .ram_oe   (ram_oe),
        .ram_q    (ram_q),
        .ram_valid(ram_valid)
    );

    // Expected memory contents, written in grant order.
    logic [7:0] ref_mem [2048];
    logic [7:0] ram_mem [2048];

    // PIF RAM port A: fixed 1-clk read latency, valid follows oe.
    initial begin
        for (int i = 0; i < 2048; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        forever begin
            @(posedge clk);
            ram_valid <= ram_oe;
            if (ram_oe) ram_q <= ram_mem[ram_addr];
            if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    int         m_owner, m_last, m_run;
    logic [10:0] m_addr;
    bit         m_rv_nxt [2];
    logic [7:0] m_pend [2];
    logic [7:0] m_rdata [2];

    bit          cur_v [2];
    bit          cur_we [2];
    logic [10:0] cur_addr [2];
    logic [7:0]  cur_wdata [2];
    txn_t        q0 [$];
    txn_t        q1 [$];
    bit          lock_drv = 1'b0;

    bit         track = 1'b0;
    int         gseq [$];
    logic [7:0] obs_rdata [2];
    int         run0_cur = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int who, input bit we, input logic [10:0] addr,
                        input logic [7:0] wdata);
        txn_t t;
        t.we = we;
        t.addr = addr;
        t.wdata = wdata;
        if (who == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last = 1;
        m_run = 0;
        m_addr = '0;
        m_rv_nxt = '{default: 1'b0};
        m_rdata = '{default: 8'h00};
        cur_v = '{default: 1'b0};
        q0.delete();
        q1.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_r0_gnt"}, 32'(r0_gnt), 0);
        check_eq({tag, "_r1_gnt"}, 32'(r1_gnt), 0);
        check_eq({tag, "_r0_rvalid"}, 32'(r0_rvalid), 0);
        check_eq({tag, "_r1_rvalid"}, 32'(r1_rvalid), 0);
        check_eq({tag, "_r0_rdata"}, 32'(r0_rdata), 0);
        check_eq({tag, "_r1_rdata"}, 32'(r1_rdata), 0);
        check_eq({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check_eq({tag, "_ram_wren"}, 32'(ram_wren), 0);
        check_eq({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
        check_eq({tag, "_ram_oe"}, 32'(ram_oe), 0);
    endtask

    // One clock: drive at negedge, compare 1ns later, then advance the model.
    task automatic step();
        txn_t t;
        bit   req [2];
        int   g;
        int   o;
        bit   exp_we;
        @(negedge clk);
        if (!cur_v[0] && q0.size() != 0) begin
            t = q0.pop_front();
            cur_v[0] = 1'b1; cur_we[0] = t.we; cur_addr[0] = t.addr; cur_wdata[0] = t.wdata;
        end
        if (!cur_v[1] && q1.size() != 0) begin
            t = q1.pop_front();
            cur_v[1] = 1'b1; cur_we[1] = t.we; cur_addr[1] = t.addr; cur_wdata[1] = t.wdata;
        end
        r0_req   = cur_v[0];
        r0_we    = cur_v[0] ? cur_we[0] : 1'($urandom);
        r0_addr  = cur_v[0] ? cur_addr[0] : 11'($urandom);
        r0_wdata = cur_v[0] ? cur_wdata[0] : 8'($urandom);
        r1_req   = cur_v[1];
        r1_we    = cur_v[1] ? cur_we[1] : 1'($urandom);
        r1_addr  = cur_v[1] ? cur_addr[1] : 11'($urandom);
        r1_wdata = cur_v[1] ? cur_wdata[1] : 8'($urandom);
`ifdef PIF_RAM_ARB_LOCK_EN
        r0_lock  = lock_drv;
`endif
        #1;
        req[0] = cur_v[0];
        req[1] = cur_v[1];
        g = -1;
        if (m_owner >= 0 && req[m_owner]) g = m_owner;
        exp_we = 1'b0;
        if (g >= 0) begin
            exp_we = cur_we[g];
            m_addr = cur_addr[g];
        end
        for (int i = 0; i < 2; i++) if (m_rv_nxt[i]) m_rdata[i] = m_pend[i];

        check_eq("r0_gnt", 32'(r0_gnt), 32'(g == 0));
        check_eq("r1_gnt", 32'(r1_gnt), 32'(g == 1));
        check_eq("ram_wren", 32'(ram_wren), 32'(g >= 0 && exp_we));
        check_eq("ram_oe", 32'(ram_oe), 32'(g >= 0 && !exp_we));
        check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
        if (g >= 0 && exp_we) check_eq("ram_wdata", 32'(ram_wdata), 32'(cur_wdata[g]));
        check_eq("r0_rvalid", 32'(r0_rvalid), 32'(m_rv_nxt[0]));
        check_eq("r1_rvalid", 32'(r1_rvalid), 32'(m_rv_nxt[1]));
        check_eq("r0_rdata", 32'(r0_rdata), 32'(m_rdata[0]));
        check_eq("r1_rdata", 32'(r1_rdata), 32'(m_rdata[1]));

        if (r0_rvalid) obs_rdata[0] = r0_rdata;
        if (r1_rvalid) obs_rdata[1] = r1_rdata;
        if (track) gseq.push_back(r0_gnt ? 0 : (r1_gnt ? 1 : -1));
        if (r0_gnt) run0_cur++;
        else if (r1_gnt) run0_cur = 0;

        m_rv_nxt = '{default: 1'b0};
        if (g >= 0) begin
            if (exp_we) ref_mem[cur_addr[g]] = cur_wdata[g];
            else begin
                m_rv_nxt[g] = 1'b1;
                m_pend[g] = ref_mem[cur_addr[g]];
            end
        end

        if (m_owner < 0) begin
            if (req[0] && (m_last == 1 || !req[1])) m_owner = 0;
            else if (req[1]) m_owner = 1;
            m_run = 0;
        end else begin
            o = m_owner;
            if (g == o && m_run < MAX_BURST) m_run++;
            if (!req[o]) begin
                m_run = 0;
                if (req[1-o]) m_owner = 1 - o;
                else begin
                    m_last = o;
                    m_owner = -1;
                end
            end else if (m_run == MAX_BURST && req[1-o] && !(o == 0 && LOCK_EN && lock_drv)) begin
                m_owner = 1 - o;
                m_run = 0;
            end
        end

        if (r0_gnt) cur_v[0] = 1'b0;
        if (r1_gnt) cur_v[1] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cur_v[0] || cur_v[1]) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_done", 32'(q0.size() + q1.size() + int'(cur_v[0]) + int'(cur_v[1])), 0);
        step();
        step();
    endtask

    task automatic analyze(output int total, output int gaps, output int bad_runs,
                           output int max0, output int max1);
        int first = -1;
        int lastg = -1;
        int run = 0;
        int prev = -2;
        total = 0; gaps = 0; bad_runs = 0; max0 = 0; max1 = 0;
        foreach (gseq[i]) if (gseq[i] >= 0) begin
            if (first < 0) first = i;
            lastg = i;
        end
        if (first >= 0) begin
            for (int i = first; i <= lastg; i++) begin
                if (gseq[i] < 0) gaps++;
                else begin
                    total++;
                    if (gseq[i] == prev) run++;
                    else begin
                        if (prev >= 0 && run != MAX_BURST) bad_runs++;
                        prev = gseq[i];
                        run = 1;
                    end
                    if (gseq[i] == 0 && run > max0) max0 = run;
                    if (gseq[i] == 1 && run > max1) max1 = run;
                end
            end
        end
        if (prev >= 0 && run != MAX_BURST) bad_runs++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int total, gaps, bad, max0, max1, n, lat;
        obs_rdata = '{default: 8'h00};
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_outputs_zero("rst0");
        @(negedge clk);
        reset = 1'b0;

        // T1: write then read back at top address
        gseq.delete();
        track = 1'b1;
        push(0, 1'b1, 11'h7FF, 8'hA5);
        drain(10);
        track = 1'b0;
        check_eq("t1_idle_cycle", 32'(gseq[0]), 32'(-1));
        check_eq("t1_gnt_latency", 32'(gseq[1]), 0);
        obs_rdata[0] = 8'h00;
        push(0, 1'b0, 11'h7FF, 8'h00);
        drain(10);
        check_eq("t1_readback", 32'(obs_rdata[0]), 32'h0A5);

        // T2: both read continuously
        gseq.delete();
        track = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(0, 1'b0, 11'($urandom), 8'h00);
            push(1, 1'b0, 11'($urandom), 8'h00);
        end
        drain(300);
        track = 1'b0;
        analyze(total, gaps, bad, max0, max1);
        check_eq("t2_total", 32'(total), 80);
        check_eq("t2_gaps", 32'(gaps), 0);
        check_eq("t2_bad_runs", 32'(bad), 0);

        // T3: only R1, no forced yield
        gseq.delete();
        track = 1'b1;
        for (int i = 0; i < 20; i++) push(1, 1'b0, 11'($urandom), 8'h00);
        drain(100);
        track = 1'b0;
        analyze(total, gaps, bad, max0, max1);
        check_eq("t3_total", 32'(total), 20);
        check_eq("t3_gaps", 32'(gaps), 0);
        check_eq("t3_run", 32'(max1), 20);

        // T4: R1 write then R0 read of the same byte
        push(1, 1'b1, 11'h040, 8'h3C);
        n = 0;
        while ((cur_v[1] || q1.size() != 0) && n < 10) begin
            step();
            n++;
        end
        check_eq("t4_w_issued", 32'(cur_v[1]), 0);
        obs_rdata[0] = 8'h00;
        push(0, 1'b0, 11'h040, 8'h00);
        drain(10);
        check_eq("t4_rdata", 32'(obs_rdata[0]), 32'h03C);

        // T5: reset right after a read grant
        push(0, 1'b0, 11'h123, 8'h00);
        n = 0;
        while ((cur_v[0] || q0.size() != 0) && n < 10) begin
            step();
            n++;
        end
        check_eq("t5_r_issued", 32'(cur_v[0]), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        r0_req = 1'b1; r1_req = 1'b1;
        #1;
        check_eq("t5_ram_valid_seen", 32'(ram_valid), 1);
        check_eq("t5_rvalid", 32'(r0_rvalid), 0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            r0_addr = 11'($urandom); r1_addr = 11'($urandom);
            r0_we = 1'($urandom); r1_we = 1'($urandom);
            #1 check_outputs_zero("t5_rst");
        end
        @(negedge clk);
        r0_req = 1'b0; r1_req = 1'b0;
        reset = 1'b0;
        repeat (3) step();

        // Random mixed traffic over a small address window
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 99) < 55)
                push(0, 1'($urandom), 11'($urandom_range(0, 15)), 8'($urandom));
            if (q1.size() == 0 && $urandom_range(0, 99) < 55)
                push(1, 1'($urandom), 11'($urandom_range(0, 15)), 8'($urandom));
            if (LOCK_EN && $urandom_range(0, 19) == 0) lock_drv = !lock_drv;
            step();
        end
        lock_drv = 1'b0;
        drain(200);

`ifdef PIF_RAM_ARB_LOCK_EN
        // T6: lock keeps R0 past MAX_BURST; dropping it hands over promptly
        gseq.delete();
        track = 1'b1;
        lock_drv = 1'b1;
        run0_cur = 0;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            push(0, 1'b0, 11'($urandom), 8'h00);
            push(1, 1'b0, 11'($urandom), 8'h00);
        end
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cur_v[0] || cur_v[1]) && n < 400) begin
            step();
            n++;
            if (lat >= 0 && lat < 100) begin
                lat++;
                if (r1_gnt) lat = lat + 100;
            end
            if (lock_drv && run0_cur >= 20) begin
                lock_drv = 1'b0;
                lat = 0;
            end
        end
        track = 1'b0;
        drain(50);
        analyze(total, gaps, bad, max0, max1);
        check_eq("t6_long_run", 32'(max0 > MAX_BURST), 1);
        check_eq("t6_unlock_handover", 32'(lat >= 100 && lat <= 102), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
